pipe_hazard_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It shadows the destination and source register fields of the EX, MEM and WB stages. From these it generates EX-stage operand forwarding selects, load-use stalls, taken-branch flushes and a global freeze on a busy data memory. It sits beside the per-instruction decoder and drives the enables and flushes of the PC and pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS32 pipeline: shadows EX/MEM/WB register
// fields and produces forwarding selects, load-use stalls, branch flushes and memory freezes.
module pipe_hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_writereg,
  input  logic            id_mem2reg,
  input  logic [REGW-1:0] id_dstreg,
  input  logic            ex_branch_taken,
  input  logic            mem_busy,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_cycles
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [REGW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
  logic            ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;
  logic            ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
  logic [REGW-1:0] mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
  logic            mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
  logic [CNTW-1:0] stall_q, stall_d;

  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b, load_use;

  // Register 0 is hardwired, so a write to it never produces a forward.
  assign mem_hit_a = ex_uses_rs_q && mem_wr_q && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q);
  assign mem_hit_b = ex_uses_rt_q && mem_wr_q && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q);
  assign wb_hit_a  = ex_uses_rs_q && wb_wr_q  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rs_q);
  assign wb_hit_b  = ex_uses_rt_q && wb_wr_q  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rt_q);

  assign fwd_a = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
  assign fwd_b = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

  assign load_use = id_valid && ex_ld_q && ex_wr_q && (ex_dst_q != '0) &&
                    ((id_uses_rs && (id_rs == ex_dst_q)) || (id_uses_rt && (id_rt == ex_dst_q)));

  // Freeze beats branch, branch beats load-use (the ID instruction is wrong-path).
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_dst_d     = ex_dst_q;
    ex_uses_rs_d = ex_uses_rs_q;
    ex_uses_rt_d = ex_uses_rt_q;
    ex_wr_d      = ex_wr_q;
    ex_ld_d      = ex_ld_q;
    mem_dst_d    = mem_dst_q;
    mem_wr_d     = mem_wr_q;
    wb_dst_d     = wb_dst_q;
    wb_wr_d      = wb_wr_q;
    if (!mem_busy) begin
      wb_dst_d  = mem_dst_q;
      wb_wr_d   = mem_wr_q;
      mem_dst_d = ex_dst_q;
      mem_wr_d  = ex_wr_q;
      if (idex_flush || !id_valid) begin
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_dst_d     = '0;
        ex_uses_rs_d = 1'b0;
        ex_uses_rt_d = 1'b0;
        ex_wr_d      = 1'b0;
        ex_ld_d      = 1'b0;
      end else begin
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_dst_d     = id_dstreg;
        ex_uses_rs_d = id_uses_rs;
        ex_uses_rt_d = id_uses_rt;
        ex_wr_d      = id_writereg;
        ex_ld_d      = id_mem2reg;
      end
    end
    stall_d = stall_q;
    if (!pc_en && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dst_q     <= '0;
      ex_uses_rs_q <= 1'b0;
      ex_uses_rt_q <= 1'b0;
      ex_wr_q      <= 1'b0;
      ex_ld_q      <= 1'b0;
      mem_dst_q    <= '0;
      mem_wr_q     <= 1'b0;
      wb_dst_q     <= '0;
      wb_wr_q      <= 1'b0;
      stall_q      <= '0;
    end else begin
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dst_q     <= ex_dst_d;
      ex_uses_rs_q <= ex_uses_rs_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      ex_wr_q      <= ex_wr_d;
      ex_ld_q      <= ex_ld_d;
      mem_dst_q    <= mem_dst_d;
      mem_wr_q     <= mem_wr_d;
      wb_dst_q     <= wb_dst_d;
      wb_wr_q      <= wb_wr_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic checked against
// an in-flight instruction model. A narrow counter makes saturation reachable.
module tb_pipe_hazard_ctrl;
  localparam int REGW = 5;
  localparam int CNTW = 6;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            id_valid, id_uses_rs, id_uses_rt, id_writereg, id_mem2reg;
  logic [REGW-1:0] id_rs, id_rt, id_dstreg;
  logic            ex_branch_taken, mem_busy;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0]      fwd_a, fwd_b;
  logic [CNTW-1:0] stall_cycles;

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writereg(id_writereg),
    .id_mem2reg(id_mem2reg), .id_dstreg(id_dstreg), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [REGW-1:0] rs, rt, dst;
    logic urs, urt, wr, ld;
  } instr_t;

  // Model: the instructions currently sitting in EX, MEM and WB.
  instr_t m_ex, m_mem, m_wb;
  int     m_cnt;
  logic [6:0] exp_ctrl;
  logic [1:0] exp_fa, exp_fb;
  int     exp_cnt;
  int     total = 0, bad = 0;

  wire [6:0] got_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  localparam logic [6:0] C_RUN    = 7'b1111100;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_BRANCH = 7'b1111111;
  localparam logic [6:0] C_STALL  = 7'b0011101;

  function automatic logic [1:0] m_fwd(input logic uses, input logic [REGW-1:0] src);
    if (uses && m_mem.wr && m_mem.dst != 0 && m_mem.dst == src) return 2'b10;
    if (uses && m_wb.wr && m_wb.dst != 0 && m_wb.dst == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic instr_t cur_id();
    instr_t t;
    t.rs = id_rs; t.rt = id_rt; t.dst = id_dstreg;
    t.urs = id_uses_rs; t.urt = id_uses_rt; t.wr = id_writereg; t.ld = id_mem2reg;
    return t;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
  endtask

  task automatic set_instr(input logic v, input int dst, input int rs, input int rt,
                           input logic urs, input logic urt, input logic wr, input logic ld);
    id_valid = v; id_dstreg = REGW'(dst); id_rs = REGW'(rs); id_rt = REGW'(rt);
    id_uses_rs = urs; id_uses_rt = urt; id_writereg = wr; id_mem2reg = ld;
  endtask

  task automatic set_idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  // Wait to mid-cycle and work out what the outputs should be right now.
  task automatic settle();
    logic hz;
    @(negedge clk);
    hz = id_valid && m_ex.ld && m_ex.wr && m_ex.dst != 0 &&
         ((id_uses_rs && id_rs == m_ex.dst) || (id_uses_rt && id_rt == m_ex.dst));
    if (mem_busy) exp_ctrl = C_FREEZE;
    else if (ex_branch_taken) exp_ctrl = C_BRANCH;
    else if (hz) exp_ctrl = C_STALL;
    else exp_ctrl = C_RUN;
    exp_fa = m_fwd(m_ex.urs, m_ex.rs);
    exp_fb = m_fwd(m_ex.urt, m_ex.rt);
    exp_cnt = m_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!mem_busy) begin
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = (exp_ctrl[0] || !id_valid) ? instr_t'('0) : cur_id();
    end
    if (!exp_ctrl[6] && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1; #2; rst = 0;
    model_reset();
  endtask

  task automatic drain();
    set_idle();
    repeat (3) begin settle(); tick(); end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; #2;
    total++; if (got_ctrl !== C_RUN) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", got_ctrl, C_RUN); end
    total++; if ({fwd_a, fwd_b} !== 4'b0) begin bad++; $display("FAIL reset_fwd got=%b want=0000", {fwd_a, fwd_b}); end
    total++; if (stall_cycles !== 0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cycles); end
    rst = 0; model_reset();
    // Reset while a load-use hazard is frozen must discard it.
    set_instr(1, 3, 1, 0, 1, 0, 1, 1); settle(); tick();
    set_instr(1, 4, 5, 3, 1, 1, 1, 0); mem_busy = 1; settle(); tick();
    mem_busy = 0; rst = 1; #1;
    total++; if (got_ctrl !== C_RUN) begin bad++; $display("FAIL reset_midstall_ctrl got=%b want=%b", got_ctrl, C_RUN); end
    total++; if (stall_cycles !== 0) begin bad++; $display("FAIL reset_midstall_cnt got=%0d want=0", stall_cycles); end
    rst = 0; model_reset();
    drain();
    $display("test_reset done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_forwarding();
    // add $3 <- $1,$2 ; sub $4 <- $3,$5
    set_instr(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();
    set_instr(1, 4, 3, 5, 1, 1, 1, 0); settle(); tick();
    set_idle(); settle();
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_mem got=%b want=10", fwd_a); end
    total++; if (fwd_b !== exp_fb) begin bad++; $display("FAIL fwd_mem_b got=%b want=%b", fwd_b, exp_fb); end
    tick(); drain();
    // with a nop in between the producer is in WB
    set_instr(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();
    set_idle(); settle(); tick();
    set_instr(1, 4, 3, 5, 1, 1, 1, 0); settle(); tick();
    set_idle(); settle();
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b want=01", fwd_a); end
    tick(); drain();
    // two writers of $3: the younger (MEM) wins
    set_instr(1, 3, 1, 2, 1, 1, 1, 0); settle(); tick();
    set_instr(1, 3, 6, 7, 1, 1, 1, 0); settle(); tick();
    set_instr(1, 4, 3, 3, 1, 1, 1, 0); settle(); tick();
    set_idle(); settle();
    total++; if ({fwd_a, fwd_b} !== 4'b1010) begin bad++; $display("FAIL fwd_prio got=%b want=1010", {fwd_a, fwd_b}); end
    tick(); drain();
    $display("test_forwarding done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1, 3, 1, 0, 1, 0, 1, 1); settle(); tick();
    set_instr(1, 4, 5, 3, 1, 1, 1, 0); settle();
    total++; if (got_ctrl !== C_STALL) begin bad++; $display("FAIL lu_ctrl got=%b want=%b", got_ctrl, C_STALL); end
    tick(); settle();
    total++; if (got_ctrl !== C_RUN) begin bad++; $display("FAIL lu_release got=%b want=%b", got_ctrl, C_RUN); end
    total++; if (stall_cycles !== 1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cycles); end
    tick(); set_idle(); settle();
    total++; if (fwd_b !== 2'b01) begin bad++; $display("FAIL lu_fwd got=%b want=01", fwd_b); end
    tick(); drain();
    $display("test_load_use done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_zero_reg();
    set_instr(1, 0, 1, 0, 1, 0, 1, 1); settle(); tick();
    set_instr(1, 4, 0, 0, 1, 1, 1, 0); settle();
    total++; if (got_ctrl !== C_RUN) begin bad++; $display("FAIL zero_nostall got=%b want=%b", got_ctrl, C_RUN); end
    tick(); set_idle(); settle();
    total++; if ({fwd_a, fwd_b} !== 4'b0) begin bad++; $display("FAIL zero_fwd got=%b want=0000", {fwd_a, fwd_b}); end
    tick(); drain();
    $display("test_zero_reg done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(1, 3, 1, 0, 1, 0, 1, 1); settle(); tick();
    set_instr(1, 4, 3, 5, 1, 1, 1, 0); ex_branch_taken = 1; settle();
    total++; if (got_ctrl !== C_BRANCH) begin bad++; $display("FAIL br_ctrl got=%b want=%b", got_ctrl, C_BRANCH); end
    tick(); set_idle(); settle();
    total++; if (stall_cycles !== 0) begin bad++; $display("FAIL br_cnt got=%0d want=0", stall_cycles); end
    total++; if ({fwd_a, fwd_b} !== 4'b0) begin bad++; $display("FAIL br_bubble_fwd got=%b want=0000", {fwd_a, fwd_b}); end
    tick(); drain();
    $display("test_branch done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_instr(1, 3, 1, 0, 1, 0, 1, 1); settle(); tick();
    set_instr(1, 4, 5, 3, 1, 1, 1, 0); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (got_ctrl !== C_FREEZE) begin bad++; $display("FAIL busy_ctrl%0d got=%b want=%b", i, got_ctrl, C_FREEZE); end
      tick();
    end
    mem_busy = 0; settle();
    total++; if (got_ctrl !== C_STALL) begin bad++; $display("FAIL busy_then_stall got=%b want=%b", got_ctrl, C_STALL); end
    tick(); settle();
    total++; if (stall_cycles !== 4) begin bad++; $display("FAIL busy_cnt got=%0d want=4", stall_cycles); end
    tick();
    // saturation
    set_idle(); mem_busy = 1;
    repeat (CMAX + 8) begin settle(); tick(); end
    mem_busy = 0; settle();
    total++; if (stall_cycles !== CNTW'(CMAX)) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", stall_cycles, CMAX); end
    total++; if (int'(stall_cycles) !== exp_cnt) begin bad++; $display("FAIL sat_model got=%0d want=%0d", stall_cycles, exp_cnt); end
    tick(); drain();
    $display("test_mem_busy done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      settle();
      total++;
      if ({got_ctrl, fwd_a, fwd_b} !== {exp_ctrl, exp_fa, exp_fb} || int'(stall_cycles) !== exp_cnt) begin
        bad++;
        $display("FAIL rand%0d got=%b/%b/%b cnt=%0d want=%b/%b/%b cnt=%0d", n, got_ctrl, fwd_a, fwd_b,
                 stall_cycles, exp_ctrl, exp_fa, exp_fb, exp_cnt);
      end
      tick();
    end
    drain();
    $display("test_random done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    rst = 1;
    set_idle();
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mem_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
